// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 streaming filter.
// Mode codes, FSM states and pipeline latency.
package conv_pkg;

  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_GAUSS = 2'd1;
  localparam logic [1:0] MODE_SOBEL = 2'd2;
  localparam logic [1:0] MODE_THR   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int LAT = 2;

endpackage

// File: rtl/conv_window3x3.sv
// Two column-indexed line buffers feeding a 3x3 shift window.
// win_o[i*3+j] is row i (0=top) and column j (0=left).
module conv_window3x3
  import conv_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int IMG_W_MAX = 256,
  parameter int COL_W     = $clog2(IMG_W_MAX)
) (
  input  logic                  clk,
  input  logic                  shift_i,
  input  logic [COL_W-1:0]      col_i,
  input  logic [PIX_W-1:0]      pix_i,
  output logic [8:0][PIX_W-1:0] win_o
);

  logic [PIX_W-1:0] lb0_q [IMG_W_MAX];
  logic [PIX_W-1:0] lb1_q [IMG_W_MAX];
  logic [PIX_W-1:0] w_q [3][3];
  logic [PIX_W-1:0] top, mid;

  assign top = lb0_q[col_i];
  assign mid = lb1_q[col_i];

  // lb0 holds row r-2, lb1 row r-1; each shift ages a column by one row
  always_ff @(posedge clk) begin
    if (shift_i) begin
      lb0_q[col_i] <= mid;
      lb1_q[col_i] <= pix_i;
      for (int i = 0; i < 3; i++) begin
        w_q[i][0] <= w_q[i][1];
        w_q[i][1] <= w_q[i][2];
      end
      w_q[0][2] <= top;
      w_q[1][2] <= mid;
      w_q[2][2] <= pix_i;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_o[i*3+j] = w_q[i][j];
      end
    end
  end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 filter: frame FSM, raster counters,
// centre-address tracking and the four-mode datapath.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int IMG_W_MAX = 256,
  parameter int DIM_W     = 9,
  parameter int ADDR_W    = 16,
  parameter int THRESH    = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  input  logic [PIX_W-1:0]  in_pixel,
  output logic              in_ready,
  output logic              out_valid,
  output logic [PIX_W-1:0]  out_pixel,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int COL_W = $clog2(IMG_W_MAX);
  localparam int EW    = PIX_W + 4;
  localparam logic [DIM_W-1:0] WMAX = DIM_W'(IMG_W_MAX);
  localparam logic [EW-1:0] PMAX = EW'((1 << PIX_W) - 1);
  localparam logic [EW-1:0] THR  = EW'(THRESH);

  state_e state_q, state_d;
  logic [DIM_W-1:0]  col_q, row_q, w_q, h_q;
  logic [ADDR_W-1:0] idx_q, a1_q, oa_q;
  logic [1:0]        mode_q;
  logic              flush_q, v1_q, ov_q, err_q;
  logic [PIX_W-1:0]  op_q;

  logic hs, bad, go, col_end, last;
  logic [8:0][PIX_W-1:0] win;
  logic [PIX_W-1:0] res;

  assign bad = (img_w < DIM_W'(3)) || (img_h < DIM_W'(3)) ||
               (img_w > WMAX);
  assign go      = (state_q == IDLE) && start;
  assign hs      = in_valid && (state_q == RUN);
  assign col_end = (col_q == w_q - DIM_W'(1));
  assign last    = hs && col_end && (row_q == h_q - DIM_W'(1));

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && !bad) state_d = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (last) state_d = FLUSH;
      end
      FLUSH: begin
        if (flush_q) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
      mode_q  <= MODE_PASS;
      flush_q <= 1'b0;
      v1_q    <= 1'b0;
      a1_q    <= '0;
      ov_q    <= 1'b0;
      op_q    <= '0;
      oa_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= go && bad;
      flush_q <= (state_q == FLUSH) ? ~flush_q : 1'b0;
      if (go && !bad) begin
        w_q    <= img_w;
        h_q    <= img_h;
        mode_q <= mode;
        col_q  <= '0;
        row_q  <= '0;
        idx_q  <= '0;
      end
      if (hs) begin
        idx_q <= idx_q + ADDR_W'(1);
        if (col_end) begin
          col_q <= '0;
          row_q <= row_q + DIM_W'(1);
        end else begin
          col_q <= col_q + DIM_W'(1);
        end
      end
      // centre sits one row and one column behind the input pixel
      v1_q <= hs && (row_q >= DIM_W'(2)) && (col_q >= DIM_W'(2));
      a1_q <= idx_q - ADDR_W'(w_q) - ADDR_W'(1);
      ov_q <= v1_q;
      if (v1_q) begin
        op_q <= res;
        oa_q <= a1_q;
      end
    end
  end

  conv_window3x3 #(
    .PIX_W     (PIX_W),
    .IMG_W_MAX (IMG_W_MAX),
    .COL_W     (COL_W)
  ) u_win (
    .clk     (clk),
    .shift_i (hs),
    .col_i   (col_q[COL_W-1:0]),
    .pix_i   (in_pixel),
    .win_o   (win)
  );

  logic [EW-1:0] p [9];
  logic [EW-1:0] gsum, lft, rgt, top, bot, ax, ay, mag;
  logic signed [EW-1:0] gx, gy;

  always_comb begin
    for (int k = 0; k < 9; k++) p[k] = EW'(win[k]);
    gsum = p[0] + (p[1] << 1) + p[2] +
           (p[3] << 1) + (p[4] << 2) + (p[5] << 1) +
           p[6] + (p[7] << 1) + p[8];
    lft = p[0] + (p[3] << 1) + p[6];
    rgt = p[2] + (p[5] << 1) + p[8];
    top = p[0] + (p[1] << 1) + p[2];
    bot = p[6] + (p[7] << 1) + p[8];
    gx  = signed'(rgt - lft);
    gy  = signed'(bot - top);
    ax  = gx[EW-1] ? unsigned'(-gx) : unsigned'(gx);
    ay  = gy[EW-1] ? unsigned'(-gy) : unsigned'(gy);
    mag = ax + ay;
    res = '0;
    unique case (mode_q)
      MODE_PASS:  res = win[4];
      MODE_GAUSS: res = gsum[PIX_W+3:4];
      MODE_SOBEL: res = (mag > PMAX) ? '1 : mag[PIX_W-1:0];
      MODE_THR:   res = (mag >= THR) ? '1 : '0;
      default:    res = '0;
    endcase
  end

  assign out_valid = ov_q;
  assign out_pixel = op_q;
  assign out_addr  = oa_q;
  assign err       = err_q;

endmodule
